decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
Registered decode-and-control stage that sits between the IF/ID latch and the execute stage of the pipelined core. It generalises the combinational control unit:
- full load/store width decode
- I-type ALU ops and XOR
- BEQ/BNE distinction
- immediate generation
- illegal-instruction flagging

It also owns the ID/EX control register, load-use hazard detection (stall plus bubble), branch flush and saturating stall/flush performance counters.

Parameters:
XLEN, 64, datapath width; immediates are sign-extended to this width.
REG_AW, 5, register index width.
ALU_CW, 3, alu_control width; codes are the `ALU_ADD/`ALU_SUB/`ALU_AND/`ALU_OR macros in definitions.sv plus a new `ALU_XOR.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  instr holds a valid instruction
instr  in  32  instruction word from IF/ID
id_ready  out  1  ID accepts instr this cycle; 0 means IF/ID must hold
flush  in  1  taken branch resolved in EX; kill ID and EX contents
ex_ready  in  1  EX can accept a new entry; 0 means hold the ID/EX register
ex_valid  out  1  ID/EX entry valid
ex_alu_control  out  ALU_CW  ALU operation
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each  control bits, same meaning as the existing control unit
ex_branch_ne  out  1  1 = BNE, 0 = BEQ
ex_mem_size  out  3  funct3 of the load/store, passed through
ex_illegal  out  1  entry is an undecodable instruction
ex_rs1, ex_rs2, ex_rd  out  REG_AW each  register indices
ex_imm  out  XLEN  sign-extended immediate
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  flush events, saturating

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all ex_* outputs = 0, including ex_alu_control = `ALU_ADD (0).
  - stall_cnt = flush_cnt = 0.
  - id_ready = 1 combinationally while in reset.
- Decode:
  - Opcode 0000011, load: funct3 in {000..110} legal. reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, ADD, I-immediate.
  - Opcode 0010011, I-ALU: funct3 000 ADDI→ADD, 100 XORI→XOR, 110 ORI→OR, 111 ANDI→AND. reg_write=1, alu_src=1, I-immediate. Other funct3 values are illegal.
  - Opcode 0100011, store: funct3 {000..011} legal. mem_write=1, alu_src=1, ADD, S-immediate.
  - Opcode 0110011, R-type: funct3 000 → ADD, or SUB when funct7=0100000; 100 XOR; 110 OR; 111 AND. reg_write=1. Other funct3, or funct7 not in {0000000, 0100000}, is illegal.
  - Opcode 1100011, branch: funct3 000 BEQ / 001 BNE. branch=1, SUB, B-immediate (bit0=0). Other funct3 values are illegal.
  - Anything else is illegal. An illegal entry has all control bits 0 and ex_illegal=1, and still loads with ex_valid=1.
- Source usage:
  - rs1 is used by all legal formats.
  - rs2 is used by store, R-type and branch only.
- Load-use hazard is the combinational condition (hz) where all of the following hold:
  - ex_valid=1, ex_mem_read=1, ex_rd≠0
  - if_valid=1
  - ex_rd equals a used source of the ID instruction
- id_ready = !rst_n | flush | (ex_ready & !hz). Note that if_valid=0 still gives id_ready=1.
- ID/EX register update priority on each clk rising edge (exactly one rule applies):
  1. flush=1: ex_valid←0, all control bits←0; the ID instruction is discarded; flush_cnt++.
  2. ex_ready=0: hold all ex_* outputs.
  3. hz=1: insert a bubble (ex_valid←0, control bits←0); IF/ID holds; stall_cnt++.
  4. Otherwise: load the decode of instr, with ex_valid←if_valid. When if_valid=0, control bits←0.
- Latency: decode appears on ex_* one cycle after acceptance. A load-use pair costs exactly one bubble.
- Counters:
  - Saturate at 2^CNT_W−1; no wrap.
  - Flush and stall never count in the same cycle, because flush has priority.
- Reset asserted mid-stall: registers clear immediately. On release, the first edge loads instr normally.

Test Plan:
1. Reset: hold rst_n=0 with random instr → all ex_* = 0, counters = 0, id_ready = 1. Release, then apply instr=0xFFF00093 (ADDI x1,x0,-1) → next cycle: ex_valid=1, reg_write=1, alu_src=1, ex_alu_control=`ALU_ADD, ex_rd=1, ex_imm=all ones.
2. Load-use: apply 0x00813283 (LD x5,8(x2)) then 0x00128333 (ADD x6,x5,x1) → the LD entry has mem_read=1, mem_size=011, imm=8. Next cycle: id_ready=0 and a bubble with ex_valid=0. Following cycle: the ADD entry with ex_rs1=5. stall_cnt=1.
3. No false hazard: LD x0,… followed by ADD x6,x0,x1 → no stall. LD x5 followed by ADDI x7,x1,… using rs2-field bits=5 → no stall, because rs2 is unused for I-type.
4. R and branch decode: 0x402081B3 (SUB x3,x1,x2) → `ALU_SUB, reg_write=1, alu_src=0. Then 0xFE209EE3 (BNE x1,x2,-4) → branch=1, branch_ne=1, `ALU_SUB, ex_imm=−4 sign-extended.
5. Flush and backpressure:
   - flush=1 together with a valid instr → next cycle ex_valid=0, flush_cnt=1.
   - flush asserted during hz → flush wins, stall_cnt unchanged.
   - ex_ready=0 for 3 cycles → ex_* stable, id_ready=0.
6. Illegal and saturation:
   - instr=0x0000007F → ex_valid=1, ex_illegal=1, all control bits 0.
   - With CNT_W=2, 5 consecutive flushes → flush_cnt sticks at 3.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// ID stage of the pipelined core: decodes the IF/ID word into the registered ID/EX
// control entry and handles load-use stalls, branch flushes and stall/flush counters.
module decode_ctrl_pipe #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int ALU_CW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       instr,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [ALU_CW-1:0] ex_alu_control,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_branch_ne,
    output logic [2:0]        ex_mem_size,
    output logic              ex_illegal,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [ALU_CW-1:0] ALU_ADD = ALU_CW'(0);
    localparam logic [ALU_CW-1:0] ALU_SUB = ALU_CW'(1);
    localparam logic [ALU_CW-1:0] ALU_AND = ALU_CW'(2);
    localparam logic [ALU_CW-1:0] ALU_OR  = ALU_CW'(3);
    localparam logic [ALU_CW-1:0] ALU_XOR = ALU_CW'(4);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1_idx = REG_AW'(instr[19:15]);
    assign rs2_idx = REG_AW'(instr[24:20]);
    assign rd_idx  = REG_AW'(instr[11:7]);
    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    logic [ALU_CW-1:0] f3_alu;
    logic              f3_alu_ok;
    logic              funct7_ok;

    // Shared funct3 -> ALU mapping for I-ALU and R-type; SUB only exists in R-type
    always_comb begin
        f3_alu    = ALU_ADD;
        f3_alu_ok = 1'b1;
        case (funct3)
            3'b000:  f3_alu = (opcode == OP_RTYPE && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b100:  f3_alu = ALU_XOR;
            3'b110:  f3_alu = ALU_OR;
            3'b111:  f3_alu = ALU_AND;
            default: f3_alu_ok = 1'b0;
        endcase
    end

    assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    logic [ALU_CW-1:0] d_alu;
    logic              d_rw, d_mr, d_mw, d_m2r, d_src, d_br, d_bne, d_ill;
    logic [2:0]        d_size;
    logic [XLEN-1:0]   d_imm;
    logic              rs1_used, rs2_used;

    always_comb begin
        d_alu    = ALU_ADD;
        d_rw     = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_m2r    = 1'b0;
        d_src    = 1'b0;
        d_br     = 1'b0;
        d_bne    = 1'b0;
        d_ill    = 1'b0;
        d_size   = 3'b000;
        d_imm    = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_LOAD: begin
                if (funct3 != 3'b111) begin
                    d_rw     = 1'b1;
                    d_mr     = 1'b1;
                    d_m2r    = 1'b1;
                    d_src    = 1'b1;
                    d_size   = funct3;
                    d_imm    = imm_i;
                    rs1_used = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OP_IALU: begin
                if (f3_alu_ok) begin
                    d_alu    = f3_alu;
                    d_rw     = 1'b1;
                    d_src    = 1'b1;
                    d_imm    = imm_i;
                    rs1_used = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OP_STORE: begin
                if (!funct3[2]) begin
                    d_mw     = 1'b1;
                    d_src    = 1'b1;
                    d_size   = funct3;
                    d_imm    = imm_s;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OP_RTYPE: begin
                if (f3_alu_ok && funct7_ok) begin
                    d_alu    = f3_alu;
                    d_rw     = 1'b1;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OP_BRNCH: begin
                if (funct3[2:1] == 2'b00) begin
                    d_br     = 1'b1;
                    d_bne    = funct3[0];
                    d_alu    = ALU_SUB;
                    d_imm    = imm_b;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            default: d_ill = 1'b1;
        endcase
    end

    logic hz;

    // A load in EX whose destination feeds the ID instruction needs one bubble
    assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && if_valid &&
                ((rs1_used && rs1_idx == ex_rd) || (rs2_used && rs2_idx == ex_rd));

    assign id_ready = !rst_n || flush || (ex_ready && !hz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_alu_control <= ALU_ADD;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_branch_ne   <= 1'b0;
            ex_mem_size    <= 3'b000;
            ex_illegal     <= 1'b0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
            ex_imm         <= '0;
            stall_cnt      <= '0;
            flush_cnt      <= '0;
        end else if (flush || (ex_ready && (hz || !if_valid))) begin
            // Flush, bubble and empty slot all leave a fully cleared entry
            ex_valid       <= 1'b0;
            ex_alu_control <= ALU_ADD;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_branch_ne   <= 1'b0;
            ex_mem_size    <= 3'b000;
            ex_illegal     <= 1'b0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
            ex_imm         <= '0;
            if (flush) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            end else if (hz) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else if (ex_ready) begin
            ex_valid       <= 1'b1;
            ex_alu_control <= d_alu;
            ex_reg_write   <= d_rw;
            ex_mem_read    <= d_mr;
            ex_mem_write   <= d_mw;
            ex_mem_to_reg  <= d_m2r;
            ex_alu_src     <= d_src;
            ex_branch      <= d_br;
            ex_branch_ne   <= d_bne;
            ex_mem_size    <= d_size;
            ex_illegal     <= d_ill;
            ex_rs1         <= rs1_idx;
            ex_rs2         <= rs2_idx;
            ex_rd          <= rd_idx;
            ex_imm         <= d_imm;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: instruction-level reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_decode_ctrl_pipe;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    localparam logic [2:0] A_ADD = 3'd0;
    localparam logic [2:0] A_SUB = 3'd1;
    localparam logic [2:0] A_AND = 3'd2;
    localparam logic [2:0] A_OR  = 3'd3;
    localparam logic [2:0] A_XOR = 3'd4;

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00093;
    localparam logic [31:0] I_LD_X5   = 32'h00813283;
    localparam logic [31:0] I_ADD_X5  = 32'h00128333;
    localparam logic [31:0] I_LD_X0   = 32'h00813003;
    localparam logic [31:0] I_ADD_X0  = 32'h00100333;
    localparam logic [31:0] I_ADDI_R5 = 32'h00508393;
    localparam logic [31:0] I_SUB     = 32'h402081B3;
    localparam logic [31:0] I_BNE     = 32'hFE209EE3;
    localparam logic [31:0] I_SD_X5   = 32'h0052B423;
    localparam logic [31:0] I_ILL     = 32'h0000007F;

    localparam logic [31:0] TBL [8] = '{I_LD_X5, I_SD_X5, I_ADD_X5, I_BNE,
                                        I_ILL, I_SUB, 32'h02208133, I_ADDI_R5};

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu;
        logic        rw, mr, mw, m2r, src, br, bne;
        logic [2:0]  size;
        logic        ill;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
    } ent_t;

    typedef enum {K_LD, K_IA, K_ST, K_R, K_B, K_ILL} kind_e;

    logic clk;
    logic rst_n;
    logic if_valid, flush, ex_ready;
    logic [31:0] instr;
    logic id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic ex_alu_src, ex_branch, ex_branch_ne, ex_illegal;
    logic [2:0] ex_alu_control, ex_mem_size;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [63:0] ex_imm;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    decode_ctrl_pipe #(.XLEN(64), .REG_AW(5), .ALU_CW(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .id_ready(id_ready),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_alu_control(ex_alu_control), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_mem_size(ex_mem_size), .ex_illegal(ex_illegal),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t dut_ent;
    assign dut_ent = {ex_valid, ex_alu_control, ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_mem_to_reg, ex_alu_src, ex_branch, ex_branch_ne, ex_mem_size,
                      ex_illegal, ex_rs1, ex_rs2, ex_rd, ex_imm};

    function automatic kind_e kind_of(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        case (w[6:0])
            7'h03:   return (f3 != 3'd7) ? K_LD : K_ILL;
            7'h13:   return (f3 inside {3'd0, 3'd4, 3'd6, 3'd7}) ? K_IA : K_ILL;
            7'h23:   return (f3 < 3'd4) ? K_ST : K_ILL;
            7'h33:   return ((f3 inside {3'd0, 3'd4, 3'd6, 3'd7}) &&
                             (w[31:25] == 7'h00 || w[31:25] == 7'h20)) ? K_R : K_ILL;
            7'h63:   return (f3 < 3'd2) ? K_B : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'd0:    return is_sub ? A_SUB : A_ADD;
            3'd4:    return A_XOR;
            3'd6:    return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic ent_t golden(input logic [31:0] w);
        ent_t  e;
        kind_e k;
        longint v;
        e = '0;
        v = 0;
        k = kind_of(w);
        e.valid = 1'b1;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        case (k)
            K_LD:  begin e.rw = 1; e.mr = 1; e.m2r = 1; e.src = 1; e.size = w[14:12]; v = w[31:20]; end
            K_IA:  begin e.rw = 1; e.src = 1; e.alu = alu_of(w[14:12], 1'b0); v = w[31:20]; end
            K_ST:  begin e.mw = 1; e.src = 1; e.size = w[14:12]; v = w[31:25] * 32 + w[11:7]; end
            K_R:   begin e.rw = 1; e.alu = alu_of(w[14:12], w[30]); end
            K_B:   begin
                e.br = 1; e.bne = w[12]; e.alu = A_SUB;
                v = w[31] * 4096 + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
            end
            default: e.ill = 1'b1;
        endcase
        if (k == K_B) begin
            if (v >= 4096) v = v - 8192;
        end else if (v >= 2048) begin
            v = v - 4096;
        end
        e.imm = v;
        return e;
    endfunction

    ent_t m_ent;
    logic [CNT_W-1:0] m_stall, m_flush;

    function automatic bit model_hz(input ent_t cur, input logic v, input logic [31:0] w);
        kind_e k;
        k = kind_of(w);
        if (!(cur.valid && cur.mr && cur.rd != 0 && v)) return 0;
        if (k != K_ILL && w[19:15] == cur.rd) return 1;
        return (k inside {K_ST, K_R, K_B}) && w[24:20] == cur.rd;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ent   <= '0;
            m_stall <= '0;
            m_flush <= '0;
        end else if (flush) begin
            m_ent   <= '0;
            m_flush <= (int'(m_flush) < MAXC) ? m_flush + 1'b1 : m_flush;
        end else if (!ex_ready) begin
            m_ent <= m_ent;
        end else if (model_hz(m_ent, if_valid, instr)) begin
            m_ent   <= '0;
            m_stall <= (int'(m_stall) < MAXC) ? m_stall + 1'b1 : m_stall;
        end else begin
            m_ent <= if_valid ? golden(instr) : '0;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("ex_entry", dut_ent, m_ent);
            checkOutput("stall_cnt", stall_cnt, m_stall);
            checkOutput("flush_cnt", flush_cnt, m_flush);
        end
    end

    // Drives one cycle of inputs from a negedge; exp_rdy >= 0 also pins id_ready literally
    task automatic applyStimulus(input logic [31:0] w, input logic v, input logic fl,
                                 input logic er, input int exp_rdy);
        instr = w;
        if_valid = v;
        flush = fl;
        ex_ready = er;
        #1;
        checkOutput("id_ready", id_ready,
                    !rst_n || fl || (er && !model_hz(m_ent, v, w)));
        if (exp_rdy >= 0) checkOutput("id_ready_pin", id_ready, exp_rdy[0]);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        instr = '0;
        if_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            instr = $urandom;
            if_valid = 1'b1;
            #3;
            checkOutput("rst_entry", dut_ent, '0);
            checkOutput("rst_cnts", {stall_cnt, flush_cnt}, '0);
            checkOutput("rst_id_ready", id_ready, 1'b1);
            @(negedge clk);
        end
        rst_n = 1'b1;
        cmp_en = 1;

        applyStimulus(I_ADDI_M1, 1, 0, 1, -1);
        checkOutput("addi_ctrl", {ex_valid, ex_reg_write, ex_alu_src, ex_alu_control, ex_rd},
                    {1'b1, 1'b1, 1'b1, A_ADD, 5'd1});
        checkOutput("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(I_LD_X5, 1, 0, 1, -1);
        checkOutput("ld_entry", {ex_mem_read, ex_mem_size, ex_imm}, {1'b1, 3'b011, 64'd8});
        applyStimulus(I_ADD_X5, 1, 0, 1, 0);
        checkOutput("bubble", {ex_valid, stall_cnt}, {1'b0, 2'd1});
        applyStimulus(I_ADD_X5, 1, 0, 1, 1);
        checkOutput("add_after_stall", {ex_valid, ex_rs1, ex_rd}, {1'b1, 5'd5, 5'd6});

        applyStimulus(I_LD_X0, 1, 0, 1, -1);
        applyStimulus(I_ADD_X0, 1, 0, 1, 1);
        applyStimulus(I_LD_X5, 1, 0, 1, -1);
        applyStimulus(I_ADDI_R5, 1, 0, 1, 1);
        checkOutput("addi_no_stall", {ex_valid, ex_rd, stall_cnt}, {1'b1, 5'd7, 2'd1});

        applyStimulus(I_SUB, 1, 0, 1, -1);
        checkOutput("sub_ctrl", {ex_alu_control, ex_reg_write, ex_alu_src}, {A_SUB, 1'b1, 1'b0});
        applyStimulus(I_BNE, 1, 0, 1, -1);
        checkOutput("bne_ctrl", {ex_branch, ex_branch_ne, ex_alu_control}, {1'b1, 1'b1, A_SUB});
        checkOutput("bne_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        applyStimulus(I_ADDI_M1, 1, 1, 1, 1);
        checkOutput("flush_entry", {ex_valid, flush_cnt}, {1'b0, 2'd1});
        applyStimulus(I_LD_X5, 1, 0, 1, -1);
        applyStimulus(I_ADD_X5, 1, 1, 1, 1);
        checkOutput("flush_over_hz", {ex_valid, stall_cnt, flush_cnt}, {1'b0, 2'd1, 2'd2});

        applyStimulus(I_SUB, 1, 0, 1, -1);
        applyStimulus(I_BNE, 1, 0, 0, 0);
        applyStimulus(I_ILL, 1, 0, 0, 0);
        applyStimulus(I_ADD_X5, 1, 0, 0, 0);
        checkOutput("held_entry", {ex_valid, ex_alu_control, ex_rd, ex_branch}, {1'b1, A_SUB, 5'd3, 1'b0});

        applyStimulus(I_ILL, 1, 0, 1, -1);
        checkOutput("illegal", {ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write,
                                ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_control},
                    {1'b1, 1'b1, 6'b0, 3'b0});
        applyStimulus(I_SUB, 0, 0, 1, 1);
        checkOutput("no_valid", ex_valid, 1'b0);

        for (int i = 0; i < 5; i++) applyStimulus(I_SUB, 1, 1, 1, 1);
        checkOutput("flush_sat", flush_cnt, 2'd3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(I_LD_X5, 1, 0, 1, -1);
            applyStimulus(I_ADD_X5, 1, 0, 1, 0);
            applyStimulus(I_ADD_X5, 1, 0, 1, 1);
        end
        checkOutput("stall_sat", stall_cnt, 2'd3);

        // Reset dropped in the middle of a load-use stall
        applyStimulus(I_LD_X5, 1, 0, 1, -1);
        instr = I_ADD_X5;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_entry", dut_ent, '0);
        checkOutput("midrst_cnts", {stall_cnt, flush_cnt, id_ready}, {4'd0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(I_ADD_X5, 1, 0, 1, 1);
        checkOutput("post_rst_add", {ex_valid, ex_rs1, ex_rd}, {1'b1, 5'd5, 5'd6});

        for (int i = 0; i < 24; i++)
            applyStimulus(TBL[i % 8], (i % 6) != 5, (i % 9) == 8, (i % 5) != 3, -1);

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
